// File: rtl/pc_npc_sequencer_pkg.sv
// Shared types for the fetch-stage PC/nPC sequencer and the control unit.
// Redirect sources are ordered so that a larger encoding means higher priority.
// Defaults for reset PC and sequential increment live here for reuse.
package pc_npc_sequencer_pkg;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_BR   = 2'd1,
        SRC_CALL = 2'd2,
        SRC_JMPL = 2'd3
    } redir_src_e;

    typedef enum logic {
        ST_SEQ   = 1'b0,
        ST_ANNUL = 1'b1
    } seq_state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] INC_DEF      = 32'h0000_0004;

endpackage

// File: rtl/redirect_hold_reg.sv
// Holds a redirect (target, source, annul flag) that arrives while fetch is stalled.
// Latency: captured at the stalling edge, visible next cycle; cleared on the first advancing edge.
// Backpressure: LE=0 captures/merges requests, LE=1 releases; higher-priority source overwrites.
module redirect_hold_reg
    import pc_npc_sequencer_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          Clk,
    input  logic          R,
    input  logic          LE,
    input  redir_src_e    req_src,
    input  logic [AW-1:0] req_target,
    input  logic          req_annul,
    output redir_src_e    held_src,
    output logic [AW-1:0] held_target,
    output logic          held_annul
);

    redir_src_e    src_q, src_d;
    logic [AW-1:0] tgt_q, tgt_d;
    logic          annul_q, annul_d;

    always_comb begin
        src_d   = src_q;
        tgt_d   = tgt_q;
        annul_d = annul_q;
        if (LE) begin
            src_d   = SRC_NONE;
            tgt_d   = '0;
            annul_d = 1'b0;
        end else begin
            // Equal priority keeps the first request seen in the stall.
            if (req_src > src_q) begin
                src_d = req_src;
                tgt_d = req_target;
            end
            annul_d = annul_q | req_annul;
        end
    end

    always_ff @(posedge Clk or negedge R) begin
        if (!R) begin
            src_q   <= SRC_NONE;
            tgt_q   <= '0;
            annul_q <= 1'b0;
        end else begin
            src_q   <= src_d;
            tgt_q   <= tgt_d;
            annul_q <= annul_d;
        end
    end

    assign held_src    = src_q;
    assign held_target = tgt_q;
    assign held_annul  = annul_q;

endmodule

// File: rtl/pc_npc_sequencer.sv
// SPARC-style PC/nPC pair with delayed control transfer, delay-slot annul and stall-held redirects.
// Latency: redirect lands in npc at the next advancing edge, in pc one advance later.
// Backpressure: LE=0 holds PC/nPC and FSM; redirects seen during the stall are held.
module pc_npc_sequencer
    import pc_npc_sequencer_pkg::*;
#(
    parameter int            AW        = 32,
    parameter logic [AW-1:0] RESET_PC  = AW'(RESET_PC_DEF),
    parameter logic [AW-1:0] INC       = AW'(INC_DEF),
    parameter int            ALIGN_CHK = 1
) (
    input  logic          Clk,
    input  logic          R,
    input  logic          LE,
    input  logic          call_valid,
    input  logic [AW-1:0] call_target,
    input  logic          br_valid,
    input  logic          br_taken,
    input  logic          br_always,
    input  logic          br_annul,
    input  logic [AW-1:0] br_target,
    input  logic          jmpl_valid,
    input  logic [AW-1:0] jmpl_target,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] npc,
    output logic          ifid_flush,
    output logic          redirect_pending,
    output logic          misalign
);

    redir_src_e    cur_src, held_src;
    logic [AW-1:0] cur_tgt, held_tgt, sel_tgt;
    logic          annul_now, held_annul, sel_vld;

    logic [AW-1:0] pc_q, pc_d, npc_q, npc_d;
    seq_state_e    state_q, state_d;
    logic          misalign_q, misalign_d;

    always_comb begin
        cur_src = SRC_NONE;
        cur_tgt = '0;
        if (jmpl_valid) begin
            cur_src = SRC_JMPL;
            cur_tgt = jmpl_target;
        end else if (call_valid) begin
            cur_src = SRC_CALL;
            cur_tgt = call_target;
        end else if (br_valid && br_taken) begin
            cur_src = SRC_BR;
            cur_tgt = br_target;
        end
    end

    assign annul_now = br_valid & br_annul & (~br_taken | br_always);

    redirect_hold_reg #(.AW(AW)) u_hold (
        .Clk         (Clk),
        .R           (R),
        .LE          (LE),
        .req_src     (cur_src),
        .req_target  (cur_tgt),
        .req_annul   (annul_now),
        .held_src    (held_src),
        .held_target (held_tgt),
        .held_annul  (held_annul)
    );

    // A held redirect always wins over whatever is presented on the releasing cycle.
    assign sel_vld = (held_src != SRC_NONE) || (cur_src != SRC_NONE);
    assign sel_tgt = (held_src != SRC_NONE) ? held_tgt : cur_tgt;

    always_comb begin
        pc_d       = pc_q;
        npc_d      = npc_q;
        state_d    = state_q;
        misalign_d = misalign_q;
        if (LE) begin
            pc_d    = npc_q;
            npc_d   = sel_vld ? sel_tgt : npc_q + INC;
            state_d = (annul_now || held_annul) ? ST_ANNUL : ST_SEQ;
            if ((ALIGN_CHK != 0) && sel_vld && (sel_tgt[1:0] != 2'b00)) begin
                misalign_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge R) begin
        if (!R) begin
            pc_q       <= RESET_PC;
            npc_q      <= RESET_PC + INC;
            state_q    <= ST_SEQ;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            npc_q      <= npc_d;
            state_q    <= state_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc               = pc_q;
    assign npc              = npc_q;
    assign ifid_flush       = (state_q == ST_ANNUL);
    assign redirect_pending = (held_src != SRC_NONE);
    assign misalign         = misalign_q;

endmodule

// File: doc/pc_npc_sequencer.md
Name: pc_npc_sequencer

Overview:
Parametrised successor to the PC/nPC/adder/PC-mux/IF-ID-reset group in the fetch stage. It holds the SPARC-style PC/nPC pair and applies delayed-control-transfer semantics for CALL, Bcc and JMPL. It handles branch-annul of the delay slot and holds a redirect that arrives during a stall. It drives the instruction-memory address and the IF/ID flush.

Parameters:
AW, 32, address width in bits
RESET_PC, 0, PC value after reset; nPC resets to RESET_PC+INC
INC, 4, sequential increment in bytes
ALIGN_CHK, 1, 1 = flag targets whose two LSBs are non-zero

Ports:
Clk  in  1  clock, rising edge
R  in  1  reset, asynchronous, active-low
LE  in  1  advance enable; 0 = stall (hold PC/nPC)
call_valid  in  1  CALL decoded in ID
call_target  in  AW  CALL target (PC of the CALL + disp30<<2)
br_valid  in  1  Bcc decoded in ID
br_taken  in  1  condition evaluated true
br_always  in  1  branch is BA
br_annul  in  1  instruction bit 29 (a)
br_target  in  AW  branch target address
jmpl_valid  in  1  JMPL in EX
jmpl_target  in  AW  ALU result for JMPL
pc  out  AW  current fetch address to instruction memory
npc  out  AW  next PC
ifid_flush  out  1  reset pulse for the IF/ID register
redirect_pending  out  1  a redirect is held during a stall
misalign  out  1  sticky, target with [1:0]!=0 accepted

Behaviour:
- Reset (R=0, asynchronous): pc=RESET_PC, npc=RESET_PC+INC, ifid_flush=0, redirect_pending=0, misalign=0, FSM=SEQ, pending target cleared.
- Redirect select, combinational, priority jmpl_valid > call_valid > (br_valid & br_taken). The target is the matching *_target. Lower-priority requests in the same cycle are dropped.
- Advance (LE=1 at posedge):
  - pc <= npc.
  - npc <= held target if redirect_pending; otherwise the current redirect target if one is present; otherwise npc+INC.
  - All arithmetic wraps modulo 2^AW.
- Stall (LE=0):
  - pc and npc hold.
  - A redirect arriving in this cycle is stored in the pending register and sets redirect_pending=1.
  - A second redirect during the same stall overwrites the held one only if it has higher priority.
  - redirect_pending clears on the first advancing edge.
- Annul rule: the delay slot is annulled when br_valid & br_annul & (~br_taken | br_always). This is also evaluated during a stall and held with the redirect.
- FSM states:
  - SEQ: normal operation.
  - ANNUL: entered on an advancing edge where the annul rule fires (or the held annul flag is set). While in ANNUL, ifid_flush=1 (Moore output) for exactly one cycle, so the delay-slot fetch becomes a NOP. Returns to SEQ on the next advancing edge.
  - If LE=0 while in ANNUL, the state and ifid_flush are held until LE=1.
- Taken non-BA branch with a=1: the delay slot executes, no flush.
- CALL and JMPL: never annul.
- JMPL coinciding with an ANNUL cycle: the redirect is applied and the flush is still issued.
- misalign: ALIGN_CHK=1 and a selected target has [1:0]!=0 at an advancing edge → misalign=1 until reset. The target is still loaded unmodified.
- Reset mid-stall: pending redirect and ANNUL state discarded.

Decomposition:
- Shared package: a redirect-source enum (NONE, BR, CALL, JMPL) and the RESET_PC/INC defaults; the control-unit package consumes these.
- One sub-module is natural: redirect_hold_reg (pending target, source and annul flag, with the priority-overwrite rule). The PC/nPC registers and FSM stay in the top.

Test Plan:
- Reset then LE=1 for 3 cycles → pc 0,4,8,12 and npc 4,8,12,16. Assert R=0 mid-run → pc=0 and npc=4 immediately, with no clock edge.
- br_valid=1, br_taken=1, br_target=0x40 with pc=8 → next edge pc=12, npc=0x40; following edge pc=0x40. ifid_flush stays 0.
- br_valid=1, br_taken=0, br_annul=1 at pc=8 → ifid_flush=1 for one cycle while pc=12, then pc=16; no further flush.
- BA with a=1, target 0x80 → flush while pc is the delay slot, then pc=0x80.
- LE=0 for 2 cycles with call_valid target 0x100 in the first cycle and br_taken target 0x200 in the second → redirect_pending=1 and the CALL is kept. On LE=1, npc=0x100 and redirect_pending=0.
- jmpl_valid with target 0x102 at the same time as call_valid → npc=0x102 (JMPL wins), misalign=1 and sticky until reset.
